mips_cpu_muldiv_unit: RTL
=========================

Name: mips_cpu_muldiv_unit

Overview:
Parametrised multi-cycle HI/LO multiply/divide unit for the MIPS CPU. It replaces the single-cycle combinational mult/div register.
- Multiply: result delivered after a configurable latency.
- Divide: iterative restoring divider, 1 quotient bit per cycle.
- A busy/done handshake lets the pipeline stall on MFHI/MFLO while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO register width (≥4).
- MUL_LAT, 1, cycles from start to multiply result (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch op; sampled on rising clk
- op  in  3  000 MTHI, 001 MTLO, 010 MUL, 011 DIV, 100 MADD, 101 MSUB, 11x reserved (no effect)
- sin  in  1  1 = signed MUL/DIV/MADD/MSUB, 0 = unsigned
- in_1  in  WIDTH  rs operand: dividend / multiplicand / MTHI-MTLO data
- in_2  in  WIDTH  rt operand: divisor / multiplier
- busy  out  1  operation in flight; CPU stalls HI/LO reads and new mult/div
- done  out  1  one-cycle pulse; HI/LO just updated by MUL/DIV/MADD/MSUB
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high; clock clk): hi=0, lo=0, busy=0, done=0, FSM→IDLE. Reset mid-operation aborts it and discards all internal state.
- FSM states: IDLE, MUL, DIV, FIX.
- Launch edge E0 is the rising edge where start=1 in IDLE.
- start while busy=1 is ignored, including MTHI/MTLO. hi/lo are unchanged.
- MTHI/MTLO: hi (or lo) ← in_1 at E0. busy and done stay 0.
- MUL:
  - Capture operands at E0. Product is sign/zero-extended to 2·WIDTH per sin.
  - FSM goes to MUL for MUL_LAT cycles. A down-counter starts at MUL_LAT-1.
  - {hi,lo} ← product at edge E0+MUL_LAT.
- DIV, non-zero divisor:
  - Capture |in_1| and |in_2| at E0 (raw values if sin=0). Also capture sign flags.
  - FSM goes to DIV for WIDTH cycles. Each cycle: shift remainder left, bring in the next dividend bit, subtract the divisor if remainder ≥ divisor, and shift the quotient bit in.
  - FSM then spends one cycle in FIX. If sin=1: quotient is negated if the operand signs differ, and remainder takes the dividend's sign.
  - lo ← quotient and hi ← remainder at edge E0+WIDTH+1.
- DIV, divisor 0: no iteration. At E0+1: hi ← in_1, lo ← all-ones, independent of sin.
- Signed overflow (MIN / -1): lo = MIN, hi = 0. No exception is raised.
- busy is 1 from after E0 until the result-update edge. busy falls on the same edge that hi/lo update.
- done is 1 for exactly the one cycle following the result-update edge.
- hi/lo hold their old values throughout; no intermediate values are visible.
- Operands are captured at E0. in_1/in_2 may change afterwards.
- Reserved op, or MADD/MSUB with the feature compiled out: treated as a no-op. No busy, no done.
- All arithmetic is modulo 2^(2·WIDTH) on {hi,lo}.

Optional Feature:
MULT_ACC_EN
- Defined:
  - MADD: {hi,lo} ← {hi,lo} + product.
  - MSUB: {hi,lo} ← {hi,lo} − product.
  - Product is signed or unsigned per sin. Timing is the same as MUL (result at E0+MUL_LAT).
  - The accumulate uses the {hi,lo} value present at the result-update edge.
- Undefined: op 100 and 101 are no-ops. No accumulate adder is synthesised.

Test Plan:
- WIDTH=32, MUL_LAT=2; MUL sin=1, in_1=0xFFFFFFFE, in_2=3 → busy for 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- DIV sin=0, 100/7 → busy for 33 cycles, then lo=14, hi=2. hi/lo keep their old values until the update edge.
- DIV sin=1, in_1=-7, in_2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV in_1=5, in_2=0 (sin=0 and sin=1) → after 1 cycle hi=5, lo=0xFFFFFFFF, done=1.
- Start DIV, pulse start with MTHI during cycle 5 → ignored. Assert reset at cycle 10 → next cycle hi=lo=0, busy=0, done never pulses. Then MTLO 0x1234 → lo=0x1234 with no busy.
- MULT_ACC_EN defined: hi:lo=0:5, MADD sin=0 3×4 → lo=17; then MSUB 2×9 → hi=0xFFFFFFFF, lo=0xFFFFFFFF. Undefined: same sequence leaves lo=5, no done.

Source files
------------

// File: rtl/mips_cpu_muldiv_unit.sv
// HI/LO mul/div unit: MUL (and MADD/MSUB when MULT_ACC_EN is defined) after MUL_LAT cycles, DIV after WIDTH+1 (1 if divisor 0).
// No backpressure: start is ignored while busy; done pulses once per hi/lo update.
module mips_cpu_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             sin,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MTHI = 3'b000;
  localparam logic [2:0] OP_MTLO = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MADD = 3'b100;
  localparam logic [2:0] OP_MSUB = 3'b101;

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;
  logic               is_mul_op;
  logic               mul_upd, fix_upd;

  logic [WIDTH-1:0]   mcand, mplier;
  logic               msin;
  logic [2*WIDTH-1:0] mcand_ext, mplier_ext, product, mul_res;

  logic [WIDTH-1:0]   quo, rem, dvs, rem_nxt;
  logic [WIDTH-1:0]   abs_1, abs_2;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic               neg_q, neg_r;

`ifdef MULT_ACC_EN
  logic               acc_en, acc_sub;
  assign is_mul_op = (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
`else
  assign is_mul_op = (op == OP_MUL);
`endif

  assign cnt_zero = (cnt == '0);

  // Multiply path: operands are held from launch, so the product is stable for the whole MUL phase.
  assign mcand_ext  = msin ? {{WIDTH{mcand[WIDTH-1]}}, mcand}   : {{WIDTH{1'b0}}, mcand};
  assign mplier_ext = msin ? {{WIDTH{mplier[WIDTH-1]}}, mplier} : {{WIDTH{1'b0}}, mplier};
  assign product    = mcand_ext * mplier_ext;

`ifdef MULT_ACC_EN
  always_comb begin
    mul_res = product;
    if (acc_en) mul_res = acc_sub ? ({hi, lo} - product) : ({hi, lo} + product);
  end
`else
  assign mul_res = product;
`endif

  // Restoring divide step: quo doubles as the dividend shift register.
  assign abs_1   = (sin && in_1[WIDTH-1]) ? -in_1 : in_1;
  assign abs_2   = (sin && in_2[WIDTH-1]) ? -in_2 : in_2;
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, dvs});
  assign rem_nxt = rem_ge ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_DIV)   state_nxt = (in_2 == '0) ? S_FIX : S_DIV;
          else if (is_mul_op) state_nxt = S_MUL;
        end
      end
      S_MUL:   if (cnt_zero) state_nxt = S_IDLE;
      S_DIV:   if (cnt_zero) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    mul_upd = (state == S_MUL) && cnt_zero;
    fix_upd = (state == S_FIX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      msin   <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`ifdef MULT_ACC_EN
      acc_en  <= 1'b0;
      acc_sub <= 1'b0;
`endif
    end else begin
      done <= mul_upd | fix_upd;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi <= in_1;
              OP_MTLO: lo <= in_1;
              OP_DIV: begin
                cnt <= CNT_W'(WIDTH - 1);
                if (in_2 == '0) begin
                  // Divide by zero skips iteration; FIX passes these through untouched.
                  quo   <= '1;
                  rem   <= in_1;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                end else begin
                  quo   <= abs_1;
                  rem   <= '0;
                  dvs   <= abs_2;
                  neg_q <= sin & (in_1[WIDTH-1] ^ in_2[WIDTH-1]);
                  neg_r <= sin & in_1[WIDTH-1];
                end
              end
              default: begin
                if (is_mul_op) begin
                  mcand  <= in_1;
                  mplier <= in_2;
                  msin   <= sin;
                  cnt    <= CNT_W'(MUL_LAT - 1);
`ifdef MULT_ACC_EN
                  acc_en  <= op[2];
                  acc_sub <= op[0];
`endif
                end
              end
            endcase
          end
        end
        S_MUL: begin
          if (cnt_zero) {hi, lo} <= mul_res;
          else          cnt <= cnt - CNT_W'(1);
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= {quo[WIDTH-2:0], rem_ge};
          cnt <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          lo <= neg_q ? -quo : quo;
          hi <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule
